// File: rtl/tt_um_hoene_input_arbiter.sv
// ----------------------------------------------------------------------------
// tt_um_hoene_input_arbiter
//
// Multi-channel smart-LED input arbiter. Every raw data line is synchronised
// and glitch-filtered. The first channel to show a clean rising edge is
// locked, and its filtered level is forwarded to the LED protocol decoder.
// The lock is released once the locked channel has been quiet for
// IDLE_TIMEOUT cycles. Test mode pins the selection to a given channel.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous reset, active low
//   in         in   [NUM_IN]  raw asynchronous data inputs
//   test_mode  in   force lock onto test_sel, timeout disabled
//   test_sel   in   [SEL_W]   channel forced in test mode
//   out        out  filtered data of the locked channel, 0 when not locked
//   locked     out  1 = a channel is selected
//   sel        out  [SEL_W]   index of the selected channel
//   active     out  [NUM_IN]  per-channel filtered level
//
// State   | meaning
// SEARCH  | no channel selected, waiting for the first filtered rising edge
// LOCKED  | sel is forwarded to out, idle timer running (unless test mode)
// ----------------------------------------------------------------------------
module tt_um_hoene_input_arbiter #(
    parameter int NUM_IN       = 4,
    parameter int FILTER_MAX   = 3,
    parameter int IDLE_TIMEOUT = 1024,
    localparam int SEL_W       = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] in,
    input  logic              test_mode,
    input  logic [SEL_W-1:0]  test_sel,
    output logic              out,
    output logic              locked,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_IN-1:0] active
);

    localparam int CNT_W  = $clog2(FILTER_MAX + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FILTER_MAX);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    logic [NUM_IN-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]  cnt_q [NUM_IN];
    logic [CNT_W-1:0]  cnt_d [NUM_IN];
    logic [NUM_IN-1:0] filt_q, filt_d, filt_dly_q;
    logic [NUM_IN-1:0] rise;
    logic [SEL_W-1:0]  rise_idx;
    logic [SEL_W-1:0]  sel_q;
    logic [IDLE_W-1:0] idle_q;
    state_t            state_q;
    logic              sel_trans;

    // Saturating integrator with hysteresis: filt only flips at the rails.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i]  = cnt_q[i];
            filt_d[i] = filt_q[i];
            if (sync2_q[i]) begin
                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
            end
            if (cnt_d[i] == CNT_MAX)  filt_d[i] = 1'b1;
            else if (cnt_d[i] == '0)  filt_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= in;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rise = filt_q & ~filt_dly_q;

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        rise_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (rise[i]) rise_idx = SEL_W'(i);
        end
    end

    // A filt change about to land on the selected channel resets the idle
    // timer on the same edge the level changes.
    assign sel_trans = filt_d[sel_q] != filt_q[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            sel_q   <= '0;
            idle_q  <= '0;
        end else if (test_mode) begin
            state_q <= LOCKED;
            idle_q  <= '0;
            sel_q   <= (32'(test_sel) < NUM_IN) ? test_sel : '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (|rise) begin
                        sel_q   <= rise_idx;
                        state_q <= LOCKED;
                        idle_q  <= '0;
                    end
                end
                LOCKED: begin
                    if (sel_trans) begin
                        idle_q <= '0;
                    end else if (idle_q == IDLE_LAST) begin
                        state_q <= SEARCH;
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign locked = (state_q == LOCKED);
    assign sel    = sel_q;
    assign out    = locked & filt_q[sel_q];
    assign active = filt_q;

endmodule

// File: tb/tb_tt_um_hoene_input_arbiter.sv
module tb_tt_um_hoene_input_arbiter;

    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_IN-1:0] in;
    logic              test_mode;
    logic [SEL_W-1:0]  test_sel;
    logic              out;
    logic              locked;
    logic [SEL_W-1:0]  sel;
    logic [NUM_IN-1:0] active;

    int checks = 0;
    int errors = 0;

    tt_um_hoene_input_arbiter #(
        .NUM_IN(4), .FILTER_MAX(3), .IDLE_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .test_mode(test_mode),
        .test_sel(test_sel), .out(out), .locked(locked), .sel(sel),
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1ns after an edge with reset released; that edge is edge 0.
    task automatic do_reset(input logic [NUM_IN-1:0] in_val);
        rst_n     = 1'b0;
        in        = in_val;
        test_mode = 1'b0;
        test_sel  = '0;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with all inputs high
        rst_n = 1'b0; in = 4'hF; test_mode = 1'b0; test_sel = '0;
        #2;
        chk("rst_out", out, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sel", sel, 0);
        chk("rst_active", active, 0);
        do_reset(4'hF);
        tick(4);
        chk("hi_act_e4", active, 4'h0);
        tick();
        chk("hi_act_e5", active, 4'hF);
        chk("hi_lock_e5", locked, 0);
        tick();
        chk("hi_lock_e6", locked, 1);
        chk("hi_sel_e6", sel, 0);
        chk("hi_out_e6", out, 1);

        // Single channel lock on ch2, other channel ignored, then idle release
        do_reset(4'h0);
        in = 4'b0100;
        tick(4);
        chk("c2_act_e4", active, 4'h0);
        tick();
        chk("c2_act_e5", active, 4'b0100);
        chk("c2_lock_e5", locked, 0);
        chk("c2_out_e5", out, 0);
        tick();
        chk("c2_lock_e6", locked, 1);
        chk("c2_sel_e6", sel, 2);
        chk("c2_out_e6", out, 1);
        in = 4'b0110;
        tick(4);
        chk("c2_ign_sel", sel, 2);
        chk("c2_ign_out", out, 1);
        in = 4'b0000;                // edge 10: both drop
        tick(4);
        chk("c2_out_e14", out, 1);
        tick();
        chk("c2_out_e15", out, 0);
        chk("c2_act2_e15", active[2], 0);
        chk("c2_lock_e15", locked, 1);
        tick(15);
        chk("c2_lock_e30", locked, 1);
        tick();
        chk("c2_rel_e31", locked, 0);
        chk("c2_relout_e31", out, 0);
        in = 4'b1000;
        tick(5);
        chk("c3_lock_e5", locked, 0);
        tick();
        chk("c3_lock_e6", locked, 1);
        chk("c3_sel_e6", sel, 3);
        chk("c3_out_e6", out, 1);

        // Two-cycle glitch on ch0 is rejected
        do_reset(4'h0);
        in = 4'b0001;
        tick(2);
        in = 4'b0000;
        tick(10);
        chk("gl_active", active, 0);
        chk("gl_locked", locked, 0);

        // Simultaneous rise on ch1 and ch3: lowest wins
        do_reset(4'h0);
        in = 4'b1010;
        tick(6);
        chk("sim_active", active, 4'b1010);
        chk("sim_locked", locked, 1);
        chk("sim_sel", sel, 1);
        chk("sim_out", out, 1);

        // Test mode forcing, no timeout, then exit restarts the timer
        do_reset(4'h0);
        test_mode = 1'b1; test_sel = 2'd3;
        tick();
        chk("tm_locked", locked, 1);
        chk("tm_sel", sel, 3);
        chk("tm_out", out, 0);
        tick(100);
        chk("tm_nolease", locked, 1);
        chk("tm_sel100", sel, 3);
        test_sel = 2'd1;
        tick();
        chk("tm_sel_chg", sel, 1);
        test_mode = 1'b0;
        tick(15);
        chk("tmx_lock_e15", locked, 1);
        chk("tmx_sel_e15", sel, 1);
        tick();
        chk("tmx_rel_e16", locked, 0);

        // Mid-frame async reset, then re-qualification of held-high inputs
        test_mode = 1'b1; in = 4'hF;
        tick(8);
        chk("mr_out_pre", out, 1);
        chk("mr_act_pre", active, 4'hF);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_out", out, 0);
        chk("mr_locked", locked, 0);
        chk("mr_sel", sel, 0);
        chk("mr_active", active, 0);
        test_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(4);
        chk("rq_act_e4", active, 4'h0);
        tick();
        chk("rq_act_e5", active, 4'hF);
        tick();
        chk("rq_lock_e6", locked, 1);
        chk("rq_sel_e6", sel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
